tmr_vote_reg_bank: RTL and testbench
====================================

Name: tmr_vote_reg_bank

Overview:
- Parametrised bank of NCH triplicated WIDTH-bit registers with a bitwise majority voter, automatic scrubbing and fault bookkeeping.
- Successor to the fixed single-bit triplicated cells: adds width and channel generalisation, error counting and per-copy persistent-fault detection.
- Sits between control logic and the state it protects; its outputs are the voted values.

Parameters:
- WIDTH, 8, bits per channel
- NCH, 4, number of channels
- CNT_W, 16, width of the global mismatch counter
- PERSIST, 3, consecutive mismatching cycles (≥2) before a copy is declared failed

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- en  in  NCH  per-channel write enable
- d  in  NCH*WIDTH  write data; channel i occupies bits [i*WIDTH +: WIDTH]
- q  out  NCH*WIDTH  voted register contents
- cnt_clr  in  1  clears err_cnt, copy_fail and the per-copy monitors
- err_pulse  out  1  registered; any mismatch seen in the previous cycle
- err_cnt  out  CNT_W  saturating count of cycles with any mismatch
- copy_fail  out  3  sticky per-copy failure flag (bit0 = A, bit1 = B, bit2 = C)
- fail_irq  out  1  one-cycle pulse when any copy_fail bit rises
- multi_fail  out  1  copy_fail has two or more bits set; q is no longer trustworthy

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low (rstn sampled on the rising edge of clk).
- Reset values:
  - copies A, B and C: all 0
  - q = 0
  - err_pulse, fail_irq, multi_fail: 0
  - err_cnt = 0; copy_fail = 000
  - all monitors in OK with counters at 0
- Reset asserted mid-operation clears everything at the next edge; a pending write is discarded.
- Voter: q = (A&B)|(B&C)|(A&C), bitwise and combinational from the registers. d→q latency is one cycle. For binary data a majority always exists; no tie case.
- Mismatch: mis_X = OR-reduction of (X ^ q) across the whole bank, for X in {A, B, C}. any_mis = mis_A|mis_B|mis_C.
- Per-channel update, evaluated for each channel i:
  - en[i]=1: all three copies load d slice i. The write wins over scrub.
  - en[i]=0 and copies differ in channel i: all three copies load the voted slice (scrub, one cycle).
  - otherwise: hold.
- Detection uses stored state, so a mismatch coinciding with a write is still counted.
- err_pulse <= any_mis.
- err_cnt:
  - cnt_clr=1: err_cnt <= 0. Clear has priority over increment.
  - else if any_mis: increment, saturating at 2^CNT_W-1 (no wrap).
- Per-copy monitor: one FSM per copy, states OK, SUSPECT, FAILED.
  - OK→SUSPECT on mis_X, with run counter = 1.
  - SUSPECT: mis_X increments the run counter; a clean cycle returns to OK with counter 0.
  - Run counter reaching PERSIST → FAILED; copy_fail[X] sets.
  - FAILED holds until cnt_clr or reset. Mismatches while FAILED still count in err_cnt.
  - cnt_clr returns every monitor to OK, counter 0.
- fail_irq = 1 for exactly one cycle on any 0→1 transition of copy_fail. Simultaneous rises on several copies give a single pulse.
- multi_fail is combinational from copy_fail.
- Transient upsets are scrubbed in one cycle, so they never reach SUSPECT beyond count 1. Only persistent faults (stuck bits) reach FAILED.

Optional Feature:
- Macro TMR_INJECT_EN adds these ports:
  - inj_valid  in  1
  - inj_copy  in  2 (0 = A, 1 = B, 2 = C; 3 ignored)
  - inj_ch  in  $clog2(NCH)
  - inj_mask  in  WIDTH
- When inj_valid=1, the selected copy/channel loads (next value ^ inj_mask) that cycle, after write/scrub selection. The other two copies are unaffected.
- Without the macro the ports do not exist and no injection logic is generated.

Decomposition:
- Package tmr_pkg:
  - copy index enum COPY_A, COPY_B, COPY_C
  - monitor state enum MON_OK, MON_SUSPECT, MON_FAILED
  - function maj3
- Sub-module tmr_copy_monitor (run counter, FSM, fail flag), instantiated three times.

Test Plan:
- Reset, then write 8'hA5 to ch0 with en=0001 → q ch0 = 8'hA5 next cycle; err_pulse=0; err_cnt=0.
- Injection (or force) flips bit0 of copy B ch2 for one cycle → err_pulse=1 for one cycle; err_cnt=1; q unchanged; copy B restored next cycle; copy_fail=000.
- Force copy C ch1 bit3 stuck-at-1 with stored 0, PERSIST=3 → copy_fail=100 after the third mismatching cycle; fail_irq pulses once; q bit3 stays 0.
- Stuck faults on copies A and C → copy_fail=101; multi_fail=1.
- CNT_W=4 with a continuous mismatch for 20 cycles → err_cnt saturates at 15. cnt_clr asserted in the same cycle as a mismatch → err_cnt=0 and copy_fail=000.
- Assert rstn=0 for one cycle mid-write with en=1111 → all copies, q and err_cnt are 0 after that edge; the write is lost.

Source files
------------

// File: rtl/tmr_pkg.sv
// Shared types and the bitwise majority helper for the triplicated register bank.
// Declarations only: no state, no latency, no flow control.
package tmr_pkg;

    typedef enum logic [1:0] {
        COPY_A = 2'd0,
        COPY_B = 2'd1,
        COPY_C = 2'd2
    } copy_idx_e;

    typedef enum logic [1:0] {
        MON_OK      = 2'd0,
        MON_SUSPECT = 2'd1,
        MON_FAILED  = 2'd2
    } mon_state_e;

    localparam int unsigned NUM_COPIES = 3;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (b & c) | (a & c);
    endfunction

endpackage

// File: rtl/tmr_copy_monitor.sv
// Per-copy persistence monitor: counts consecutive mismatching cycles, sticky fail flag.
// Flag shows the cycle after the PERSIST-th consecutive mismatch; no backpressure.
module tmr_copy_monitor #(
    parameter int PERSIST = 3
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic mis_i,
    input  logic clr_i,
    output logic fail_o,
    output logic rise_o
);
    import tmr_pkg::*;

    localparam int RUN_W = $clog2(PERSIST + 1);

    mon_state_e       state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d, run_inc;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= MON_OK;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    assign run_inc = run_q + RUN_W'(1);

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        if (clr_i) begin
            state_d = MON_OK;
            run_d   = '0;
        end else begin
            case (state_q)
                MON_OK: begin
                    if (mis_i) begin
                        state_d = MON_SUSPECT;
                        run_d   = RUN_W'(1);
                    end
                end
                MON_SUSPECT: begin
                    if (mis_i) begin
                        run_d = run_inc;
                        if (run_inc == RUN_W'(PERSIST)) begin
                            state_d = MON_FAILED;
                        end
                    end else begin
                        state_d = MON_OK;
                        run_d   = '0;
                    end
                end
                // Only clear or reset leaves FAILED; the run counter is frozen.
                MON_FAILED: begin
                    state_d = MON_FAILED;
                end
                default: begin
                    state_d = MON_OK;
                    run_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        fail_o = (state_q == MON_FAILED);
        rise_o = (state_d == MON_FAILED) && (state_q != MON_FAILED);
    end

endmodule

// File: rtl/tmr_vote_reg_bank.sv
// NCH x WIDTH triplicated register bank: bitwise voting, one-cycle scrub, mismatch and persistent-fault bookkeeping.
// d->q one cycle, status one cycle after the mismatch, no backpressure; TMR_INJECT_EN adds fault-injection ports.
module tmr_vote_reg_bank #(
    parameter int WIDTH   = 8,
    parameter int NCH     = 4,
    parameter int CNT_W   = 16,
    parameter int PERSIST = 3
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NCH-1:0]         en,
    input  logic [NCH*WIDTH-1:0]   d,
    output logic [NCH*WIDTH-1:0]   q,
    input  logic                   cnt_clr,
    output logic                   err_pulse,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [2:0]             copy_fail,
    output logic                   fail_irq,
    output logic                   multi_fail
`ifdef TMR_INJECT_EN
    ,
    input  logic                   inj_valid,
    input  logic [1:0]             inj_copy,
    input  logic [$clog2(NCH)-1:0] inj_ch,
    input  logic [WIDTH-1:0]       inj_mask
`endif
);
    import tmr_pkg::*;

    localparam int BW = NCH * WIDTH;

    logic [BW-1:0]         copy_a_q, copy_b_q, copy_c_q;
    wire  [BW-1:0]         copy_a_d, copy_b_d, copy_c_d;
    logic [BW-1:0]         vote;
    logic [BW-1:0]         base_d;
    logic [NUM_COPIES-1:0] mis;
    logic                  any_mis;
    logic                  err_pulse_q;
    logic [CNT_W-1:0]      err_cnt_q, err_cnt_d;
    logic                  fail_irq_q;
    logic [NUM_COPIES-1:0] fail, fail_rise;

    always_comb begin
        vote = '0;
        for (int b = 0; b < BW; b++) begin
            vote[b] = maj3(copy_a_q[b], copy_b_q[b], copy_c_q[b]);
        end
    end

    assign q = vote;

    assign mis[COPY_A] = |(copy_a_q ^ vote);
    assign mis[COPY_B] = |(copy_b_q ^ vote);
    assign mis[COPY_C] = |(copy_c_q ^ vote);
    assign any_mis     = |mis;

    // Hold is only reached when all three copies agree, so copy A stands for all of them.
    always_comb begin
        base_d = copy_a_q;
        for (int i = 0; i < NCH; i++) begin
            if (en[i]) begin
                base_d[i*WIDTH +: WIDTH] = d[i*WIDTH +: WIDTH];
            end else if ((copy_a_q[i*WIDTH +: WIDTH] != copy_b_q[i*WIDTH +: WIDTH]) ||
                         (copy_b_q[i*WIDTH +: WIDTH] != copy_c_q[i*WIDTH +: WIDTH])) begin
                base_d[i*WIDTH +: WIDTH] = vote[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef TMR_INJECT_EN
    logic [BW-1:0]         inj_vec;
    logic [NUM_COPIES-1:0] inj_sel;

    always_comb begin
        inj_vec = '0;
        if (int'(inj_ch) < NCH) begin
            inj_vec[int'(inj_ch)*WIDTH +: WIDTH] = inj_mask;
        end
    end

    always_comb begin
        inj_sel = '0;
        if (inj_valid) begin
            case (copy_idx_e'(inj_copy))
                COPY_A:  inj_sel[COPY_A] = 1'b1;
                COPY_B:  inj_sel[COPY_B] = 1'b1;
                COPY_C:  inj_sel[COPY_C] = 1'b1;
                default: inj_sel = '0;
            endcase
        end
    end

    assign copy_a_d = inj_sel[COPY_A] ? (base_d ^ inj_vec) : base_d;
    assign copy_b_d = inj_sel[COPY_B] ? (base_d ^ inj_vec) : base_d;
    assign copy_c_d = inj_sel[COPY_C] ? (base_d ^ inj_vec) : base_d;
`else
    assign copy_a_d = base_d;
    assign copy_b_d = base_d;
    assign copy_c_d = base_d;
`endif

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (cnt_clr) begin
            err_cnt_d = '0;
        end else if (any_mis && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            copy_a_q    <= '0;
            copy_b_q    <= '0;
            copy_c_q    <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            fail_irq_q  <= 1'b0;
        end else begin
            copy_a_q    <= copy_a_d;
            copy_b_q    <= copy_b_d;
            copy_c_q    <= copy_c_d;
            err_pulse_q <= any_mis;
            err_cnt_q   <= err_cnt_d;
            fail_irq_q  <= |fail_rise;
        end
    end

    for (genvar x = 0; x < NUM_COPIES; x++) begin : g_mon
        tmr_copy_monitor #(
            .PERSIST (PERSIST)
        ) u_mon (
            .clk_i  (clk),
            .rstn_i (rstn),
            .mis_i  (mis[x]),
            .clr_i  (cnt_clr),
            .fail_o (fail[x]),
            .rise_o (fail_rise[x])
        );
    end

    assign err_pulse  = err_pulse_q;
    assign err_cnt    = err_cnt_q;
    assign fail_irq   = fail_irq_q;
    assign copy_fail  = fail;
    assign multi_fail = maj3(fail[COPY_A], fail[COPY_B], fail[COPY_C]);

endmodule

// File: tb/tb_tmr_vote_reg_bank.sv
// Randomised, scoreboarded bench for tmr_vote_reg_bank against a behavioural TMR model.
// Faults are planted by overriding a copy's next-state value for chosen cycles.
module tb_tmr_vote_reg_bank;
    localparam int WIDTH   = 8;
    localparam int NCH     = 4;
    localparam int CNT_W   = 4;
    localparam int PERSIST = 3;
    localparam int BW      = NCH * WIDTH;
    localparam int CMAX    = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [BW-1:0]    q;
        logic             pulse;
        logic [CNT_W-1:0] cnt;
        logic [2:0]       fail;
        logic             irq;
        logic             multi;
    } exp_t;

    logic             clk = 1'b0;
    logic             rstn;
    logic [NCH-1:0]   en;
    logic [BW-1:0]    d;
    logic [BW-1:0]    q;
    logic             cnt_clr;
    logic             err_pulse;
    logic [CNT_W-1:0] err_cnt;
    logic [2:0]       copy_fail;
    logic             fail_irq;
    logic             multi_fail;

    always #5 clk = ~clk;

    tmr_vote_reg_bank #(
        .WIDTH   (WIDTH),
        .NCH     (NCH),
        .CNT_W   (CNT_W),
        .PERSIST (PERSIST)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .d          (d),
        .q          (q),
        .cnt_clr    (cnt_clr),
        .err_pulse  (err_pulse),
        .err_cnt    (err_cnt),
        .copy_fail  (copy_fail),
        .fail_irq   (fail_irq),
        .multi_fail (multi_fail)
`ifdef TMR_INJECT_EN
        ,
        .inj_valid  (1'b0),
        .inj_copy   (2'd0),
        .inj_ch     ('0),
        .inj_mask   ('0)
`endif
    );

    // Behavioural model state
    logic [BW-1:0] m_cp [3];
    int            m_cnt;
    bit            m_pulse;
    bit            m_irq;
    int            m_run [3];
    bit            m_failed [3];
    logic [BW-1:0] st1 [3];
    logic [BW-1:0] st0 [3];
    logic [BW-1:0] tr [3];
    bit            forced [3];
    logic [BW-1:0] fva, fvb, fvc;

    exp_t exp_q [$];
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic logic [BW-1:0] vote3(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                            input logic [BW-1:0] c);
        logic [BW-1:0] v;
        for (int k = 0; k < BW; k++) begin
            v[k] = ((int'(a[k]) + int'(b[k]) + int'(c[k])) >= 2);
        end
        return v;
    endfunction

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] want);
        n_assert++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, want);
        end
    endtask

    task automatic apply_force(input int c, input bit on, input logic [BW-1:0] v);
        if (on) begin
            case (c)
                0:       begin fva = v; force dut.copy_a_d = fva; end
                1:       begin fvb = v; force dut.copy_b_d = fvb; end
                default: begin fvc = v; force dut.copy_c_d = fvc; end
            endcase
            forced[c] = 1'b1;
        end else if (forced[c]) begin
            case (c)
                0:       release dut.copy_a_d;
                1:       release dut.copy_b_d;
                default: release dut.copy_c_d;
            endcase
            forced[c] = 1'b0;
        end
    endtask

    // One clock cycle: drive inputs/faults at the falling edge, advance the model, queue expectations.
    task automatic cycle(input bit rn, input logic [NCH-1:0] e, input logic [BW-1:0] dd, input bit clr);
        logic [BW-1:0] v, nx, fv;
        logic [BW-1:0] nxt [3];
        bit            mis [3];
        bit            any, on, prev, rose;
        int            nf;
        exp_t          x;
        @(negedge clk);
        v   = vote3(m_cp[0], m_cp[1], m_cp[2]);
        any = 1'b0;
        for (int c = 0; c < 3; c++) begin
            mis[c] = (m_cp[c] != v);
            any    = any | mis[c];
        end
        for (int ch = 0; ch < NCH; ch++) begin
            if (e[ch])
                nx[ch*WIDTH +: WIDTH] = dd[ch*WIDTH +: WIDTH];
            else if (m_cp[0][ch*WIDTH +: WIDTH] != m_cp[1][ch*WIDTH +: WIDTH] ||
                     m_cp[1][ch*WIDTH +: WIDTH] != m_cp[2][ch*WIDTH +: WIDTH])
                nx[ch*WIDTH +: WIDTH] = v[ch*WIDTH +: WIDTH];
            else
                nx[ch*WIDTH +: WIDTH] = m_cp[0][ch*WIDTH +: WIDTH];
        end
        for (int c = 0; c < 3; c++) begin
            on     = rn && (st1[c] != '0 || st0[c] != '0 || tr[c] != '0);
            fv     = ((nx | st1[c]) & ~st0[c]) ^ tr[c];
            apply_force(c, on, fv);
            nxt[c] = on ? fv : nx;
        end
        rstn    = rn;
        en      = e;
        d       = dd;
        cnt_clr = clr;
        if (!rn) begin
            m_cnt   = 0;
            m_pulse = 1'b0;
            m_irq   = 1'b0;
            for (int c = 0; c < 3; c++) begin
                m_cp[c]     = '0;
                m_run[c]    = 0;
                m_failed[c] = 1'b0;
                st1[c]      = '0;
                st0[c]      = '0;
            end
        end else begin
            m_pulse = any;
            if (clr) m_cnt = 0;
            else if (any && m_cnt < CMAX) m_cnt = m_cnt + 1;
            rose = 1'b0;
            for (int c = 0; c < 3; c++) begin
                prev = m_failed[c];
                if (clr) begin
                    m_run[c]    = 0;
                    m_failed[c] = 1'b0;
                end else begin
                    m_run[c] = mis[c] ? m_run[c] + 1 : 0;
                    if (m_run[c] >= PERSIST) m_failed[c] = 1'b1;
                end
                if (m_failed[c] && !prev) rose = 1'b1;
                m_cp[c] = nxt[c];
            end
            m_irq = rose;
        end
        for (int c = 0; c < 3; c++) tr[c] = '0;
        nf      = int'(m_failed[0]) + int'(m_failed[1]) + int'(m_failed[2]);
        x.q     = vote3(m_cp[0], m_cp[1], m_cp[2]);
        x.pulse = m_pulse;
        x.cnt   = CNT_W'(m_cnt);
        x.fail  = {m_failed[2], m_failed[1], m_failed[0]};
        x.irq   = m_irq;
        x.multi = (nf >= 2);
        exp_q.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("q",          q,                   x.q);
                chk("err_pulse",  BW'(err_pulse),      BW'(x.pulse));
                chk("err_cnt",    BW'(err_cnt),        BW'(x.cnt));
                chk("copy_fail",  BW'(copy_fail),      BW'(x.fail));
                chk("fail_irq",   BW'(fail_irq),       BW'(x.irq));
                chk("multi_fail", BW'(multi_fail),     BW'(x.multi));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        int            c, ch, left;
        logic [WIDTH-1:0] m8;
        logic [NCH-1:0] e;
        logic [BW-1:0] dd;
        bit            clr, rn;

        m_cnt   = 0;
        m_pulse = 1'b0;
        m_irq   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_cp[k] = '0; m_run[k] = 0; m_failed[k] = 1'b0;
            st1[k] = '0; st0[k] = '0; tr[k] = '0; forced[k] = 1'b0;
        end
        rstn = 1'b0; en = '0; d = '0; cnt_clr = 1'b0;

        repeat (2) cycle(1'b0, '0, '0, 1'b0);
        cycle(1'b1, 4'b0001, 32'h0000_00A5, 1'b0);
        cycle(1'b1, '0, '0, 1'b0);

        // Single-cycle upset on copy B, channel 2, bit 0
        tr[1] = 32'h0001_0000;
        cycle(1'b1, '0, '0, 1'b0);
        repeat (3) cycle(1'b1, '0, '0, 1'b0);

        // Copy C channel 1 bit 3 stuck at 1
        st1[2] = 32'h0000_0800;
        repeat (6) cycle(1'b1, '0, '0, 1'b0);

        // Copy A channel 0 bit 1 also stuck at 1: two failed copies, counter saturates
        st1[0] = 32'h0000_0002;
        repeat (25) cycle(1'b1, '0, '0, 1'b0);
        cycle(1'b1, '0, '0, 1'b1);
        repeat (3) cycle(1'b1, '0, '0, 1'b0);
        st1[0] = '0;
        st1[2] = '0;
        repeat (4) cycle(1'b1, '0, '0, 1'b0);

        // Reset lands on a full-width write
        cycle(1'b1, 4'hF, 32'h1234_5678, 1'b0);
        cycle(1'b0, 4'hF, 32'hDEAD_BEEF, 1'b0);
        repeat (2) cycle(1'b1, '0, '0, 1'b0);

        left = 0;
        for (int k = 0; k < 400; k++) begin
            e = NCH'($urandom());
            if ($urandom_range(1, 0) == 0) e = '0;
            dd  = $urandom();
            clr = ($urandom_range(15, 0) == 0);
            rn  = ($urandom_range(63, 0) != 0);
            if ($urandom_range(5, 0) == 0) begin
                c  = int'($urandom_range(2, 0));
                ch = int'($urandom_range(NCH - 1, 0));
                m8 = WIDTH'($urandom());
                if (m8 == '0) m8 = WIDTH'(1);
                tr[c] = BW'(m8) << (ch * WIDTH);
            end
            if (left == 0 && $urandom_range(15, 0) == 0) begin
                c    = int'($urandom_range(2, 0));
                left = int'($urandom_range(8, 1));
                if ($urandom_range(1, 0) == 0) st1[c] = BW'(1) << $urandom_range(BW - 1, 0);
                else                           st0[c] = BW'(1) << $urandom_range(BW - 1, 0);
            end
            cycle(rn, e, dd, clr);
            if (left > 0) begin
                left--;
                if (left == 0) begin
                    for (int j = 0; j < 3; j++) begin
                        st1[j] = '0;
                        st0[j] = '0;
                    end
                end
            end
        end
        cycle(1'b1, '0, '0, 1'b0);

        @(posedge clk);
        #2;
        chk("drain", BW'(exp_q.size()), BW'(0));
        for (int j = 0; j < 3; j++) apply_force(j, 1'b0, '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
